ame_num_denormal: RTL and testbench

AME_NUM_DENORMAL -- requirements
Module: ame_num_denormal

---
 rtl/ame_num_denormal.sv | 169 ++++++++++++++++
 tb/tb_ame_num_denormal.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ame_num_denormal.sv
// Multi-cycle left shifter: logical, or signed with saturation and a sticky overflow flag.
// Latency: fixed SW+1 clocks from the sampled init to the one-cycle done pulse, for every shift amount.
// Backpressure: none; init is accepted only when idle (busy low) and is dropped otherwise.
module ame_num_denormal #(
    parameter  int COMP_DATA_BITS = 64,
    localparam int SW             = $clog2(COMP_DATA_BITS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      comp_init_i,
    input  logic                      comp_arith_i,
    input  logic [SW-1:0]             comp_shift_i,
    input  logic [COMP_DATA_BITS-1:0] comp_data_i,
    output logic                      comp_busy_o,
    output logic                      comp_done_o,
    output logic                      comp_ovf_o,
    output logic [COMP_DATA_BITS-1:0] comp_data_o
);

    localparam int N = COMP_DATA_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   k_q, k_d;
    logic [N-1:0]    work_q, work_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            arith_q, arith_d;
    logic            sign_q, sign_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    res_q, res_d;
    logic            res_ovf_q, res_ovf_d;

    logic [N-1:0]    stg_dat [SW];
    logic [SW-1:0]   stg_ovf_a;
    logic [SW-1:0]   stg_ovf_l;

    logic            sel_bit;
    logic [N-1:0]    stage_dat;
    logic            stage_ovf;
    logic [N-1:0]    work_nxt;
    logic            ovf_nxt;
    logic [N-1:0]    sat_val;
    logic [N-1:0]    result;
    logic            last_stage;

    // Stage g shifts by 2^g; signed mode keeps the value only if the bits lost
    // plus the new MSB all agree, i.e. the top 2^g+1 bits are all equal.
    for (genvar g = 0; g < SW; g++) begin : g_stage
        localparam int S = 1 << g;
        assign stg_dat[g]   = work_q << S;
        assign stg_ovf_a[g] = !((&work_q[N-1 -: S+1]) || !(|work_q[N-1 -: S+1]));
        assign stg_ovf_l[g] = |work_q[N-1 -: S];
    end

    always_comb begin
        sel_bit   = 1'b0;
        stage_dat = work_q;
        stage_ovf = 1'b0;
        for (int i = 0; i < SW; i++) begin
            if (k_q == SW'(i)) begin
                sel_bit   = shift_q[i];
                stage_dat = stg_dat[i];
                stage_ovf = arith_q ? stg_ovf_a[i] : stg_ovf_l[i];
            end
        end
    end

    assign work_nxt   = sel_bit ? stage_dat : work_q;
    assign ovf_nxt    = ovf_q | (sel_bit & stage_ovf);
    assign sat_val    = sign_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    assign result     = (arith_q && ovf_nxt) ? sat_val : work_nxt;
    assign last_stage = (k_q == SW'(SW-1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (comp_init_i) state_d = ST_SHIFT;
            ST_SHIFT: if (last_stage)  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        comp_busy_o = 1'b0;
        comp_done_o = 1'b0;
        case (state_q)
            ST_SHIFT: comp_busy_o = 1'b1;
            ST_DONE: begin
                comp_busy_o = 1'b1;
                comp_done_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        k_d       = k_q;
        work_d    = work_q;
        shift_d   = shift_q;
        arith_d   = arith_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (comp_init_i) begin
                    work_d  = comp_data_i;
                    shift_d = comp_shift_i;
                    arith_d = comp_arith_i;
                    sign_d  = comp_data_i[N-1];
                    ovf_d   = 1'b0;
                    k_d     = '0;
                end
            end
            ST_SHIFT: begin
                work_d = work_nxt;
                ovf_d  = ovf_nxt;
                k_d    = k_q + SW'(1);
                if (last_stage) begin
                    res_d     = result;
                    res_ovf_d = ovf_nxt;
                    k_d       = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_q       <= '0;
            work_q    <= '0;
            shift_q   <= '0;
            arith_q   <= 1'b0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            k_q       <= k_d;
            work_q    <= work_d;
            shift_q   <= shift_d;
            arith_q   <= arith_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign comp_data_o = res_q;
    assign comp_ovf_o  = res_ovf_q;

endmodule

// File: tb/tb_ame_num_denormal.sv
// Bench for ame_num_denormal: directed corner cases, protocol cases and a random
// scoreboard run against an independent whole-shift reference model.
module tb_ame_num_denormal;

    localparam int N  = 64;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic          arith;
    logic [SW-1:0] shamt;
    logic [N-1:0]  din;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [N-1:0]  dout;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [N-1:0] dat;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last;

    always #5 clk = ~clk;

    ame_num_denormal #(.COMP_DATA_BITS(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .comp_init_i  (init),
        .comp_arith_i (arith),
        .comp_shift_i (shamt),
        .comp_data_i  (din),
        .comp_busy_o  (busy),
        .comp_done_o  (done),
        .comp_ovf_o   (ovf),
        .comp_data_o  (dout)
    );

    // Whole-shift reference: signed mode overflows unless the top sh+1 bits agree.
    function automatic void model(input logic a, input int sh, input logic [N-1:0] d,
                                  output logic [N-1:0] r, output logic o);
        logic [N-1:0] t;
        logic [N-1:0] shifted;
        shifted = d << sh;
        if (a) begin
            t = $signed(d) >>> (N - 1 - sh);
            o = !((t == '0) || (t == '1));
            r = o ? (d[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : shifted;
        end else begin
            o = (sh != 0) && ((d >> (N - sh)) != '0);
            r = shifted;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic a, input int sh, input logic [N-1:0] d);
        exp_t         e;
        logic [N-1:0] r;
        logic         o;
        model(a, sh, d, r, o);
        e.dat = r;
        e.ovf = o;
        sb.push_back(e);
        init  = 1'b1;
        arith = a;
        shamt = SW'(sh);
        din   = d;
    endtask

    task automatic scramble();
        init  = 1'b0;
        arith = 1'($urandom);
        shamt = SW'($urandom);
        din   = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        init = 1'b1;
        arith = 1'b1;
        shamt = 6'd3;
        din  = 64'h1;
        step();
        step();
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_vec++; if (dout !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", dout); end
        rst  = 1'b0;
        init = 1'b0;
        step();
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_over_init busy got %b want 0", busy); end
        last.dat = '0;
        last.ovf = 1'b0;
    endtask

    task automatic test_directed();
        logic         a_t [8];
        int           s_t [8];
        logic [N-1:0] d_t [8];
        exp_t         e;
        a_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        s_t = '{4, 1, 2, 63, 4, 0, 0, 63};
        d_t = '{64'h0000_0000_0000_0003, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hF000_0000_0000_0001, 64'hF000_0000_0000_0001,
                64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
        for (int v = 0; v < 8; v++) begin
            issue(a_t[v], s_t[v], d_t[v]);
            for (int c = 1; c <= SW + 2; c++) begin
                step();
                if (c == 1) scramble();
                n_vec++;
                if (done !== (c == SW + 1)) begin
                    n_bad++; $display("FAIL dir%0d_done c=%0d got %b want %b", v, c, done, (c == SW + 1));
                end
                n_vec++;
                if (busy !== (c <= SW + 1)) begin
                    n_bad++; $display("FAIL dir%0d_busy c=%0d got %b want %b", v, c, busy, (c <= SW + 1));
                end
                if (c == SW + 1) begin
                    e = sb.pop_front();
                    last = e;
                end
                if (c >= SW + 1) begin
                    n_vec++;
                    if (dout !== last.dat) begin
                        n_bad++; $display("FAIL dir%0d_data c=%0d got %h want %h", v, c, dout, last.dat);
                    end
                    n_vec++;
                    if (ovf !== last.ovf) begin
                        n_bad++; $display("FAIL dir%0d_ovf c=%0d got %b want %b", v, c, ovf, last.ovf);
                    end
                end
            end
        end
    endtask

    task automatic test_reinit_ignored();
        int   n_done = 0;
        exp_t e;
        issue(1'b1, 5, 64'h0000_0000_0000_0123);
        for (int c = 1; c <= SW + 4; c++) begin
            step();
            if (c == 1) scramble();
            if (c == 3) begin
                init  = 1'b1;
                arith = 1'b0;
                shamt = 6'd1;
                din   = 64'hFFFF_0000_FFFF_0000;
            end
            if (c == 4) init = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                e = sb.pop_front();
                last = e;
                n_vec++;
                if (dout !== e.dat) begin
                    n_bad++; $display("FAIL reinit_data got %h want %h", dout, e.dat);
                end
            end
        end
        n_vec++;
        if (n_done !== 1) begin n_bad++; $display("FAIL reinit_done_count got %0d want 1", n_done); end
    endtask

    task automatic test_reset_abort();
        int   lat = 0;
        int   n_done = 0;
        exp_t e;
        issue(1'b1, 4, 64'h0000_0000_0000_0003);
        step(); scramble();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_front());
        last.dat = '0;
        last.ovf = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        n_vec++; if (dout !== '0) begin n_bad++; $display("FAIL abort_data got %h want 0", dout); end
        n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL abort_ovf got %b want 0", ovf); end
        for (int c = 0; c < SW + 3; c++) begin
            step();
            if (done === 1'b1) n_done++;
        end
        n_vec++;
        if (n_done !== 0) begin n_bad++; $display("FAIL abort_spurious_done got %0d want 0", n_done); end
        issue(1'b0, 8, 64'h0000_0000_0000_00FF);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            step();
            if (c == 1) scramble();
            if (done === 1'b1) lat = c;
        end
        n_vec++;
        if (lat !== SW + 1) begin n_bad++; $display("FAIL post_abort_latency got %0d want %0d", lat, SW + 1); end
        e = sb.pop_front();
        last = e;
        n_vec++;
        if (dout !== e.dat) begin n_bad++; $display("FAIL post_abort_data got %h want %h", dout, e.dat); end
        step();
    endtask

    task automatic test_random();
        logic         a;
        int           sh;
        logic [N-1:0] d;
        exp_t         e;
        for (int v = 0; v < 10000; v++) begin
            a  = 1'($urandom);
            sh = $urandom_range(0, N - 1);
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) d = $signed(d) >>> $urandom_range(0, N - 1);
            issue(a, sh, d);
            for (int c = 1; c <= SW + 2; c++) begin
                step();
                if (c == 1) scramble();
                n_vec++;
                if (done !== (c == SW + 1)) begin
                    n_bad++; $display("FAIL rnd%0d_done c=%0d got %b want %b", v, c, done, (c == SW + 1));
                end
                if (c == SW + 1) begin
                    e = sb.pop_front();
                    n_vec++;
                    if (dout !== e.dat || ovf !== e.ovf) begin
                        n_bad++;
                        $display("FAIL rnd%0d_result a=%b sh=%0d d=%h got %h/%b want %h/%b",
                                 v, a, sh, d, dout, ovf, e.dat, e.ovf);
                    end
                    last = e;
                end else begin
                    n_vec++;
                    if (dout !== last.dat || ovf !== last.ovf) begin
                        n_bad++;
                        $display("FAIL rnd%0d_hold c=%0d got %h/%b want %h/%b", v, c, dout, ovf, last.dat, last.ovf);
                    end
                end
            end
        end
        n_vec++;
        if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    endtask

    initial begin
        rst   = 1'b1;
        init  = 1'b0;
        arith = 1'b0;
        shamt = '0;
        din   = '0;
        test_reset();
        test_directed();
        test_reinit_ignored();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
